// File: rtl/load_store_unit.sv
// Load/store unit: aligns store data into byte lanes, runs a valid/ready data-bus handshake
// and returns extended load data. Define LSU_MISALIGN_TRAP_EN to flag misaligned accesses.
module load_store_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] store_data,
    output logic             stall,
    output logic             ld_valid,
    output logic [WIDTH-1:0] ld_data,
    output logic             misalign,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [3:0]       mem_wstrb,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [1:0]  offset_s;
    logic [1:0]  offset_r;
    logic [2:0]  funct3_r;
    logic        legal_s;
    logic        accept_s;

    function automatic logic [3:0] lane_strb(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   lane_strb = 4'b0001 << off;
            2'b01:   lane_strb = off[1] ? 4'b1100 : 4'b0011;
            default: lane_strb = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   lane_data = {4{d[7:0]}};
            2'b01:   lane_data = {2{d[15:0]}};
            default: lane_data = d;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] rdata);
        logic [31:0] sh;
        sh = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  load_extend = {{24{sh[7]}}, sh[7:0]};
            3'b001:  load_extend = {{16{sh[15]}}, sh[15:0]};
            3'b100:  load_extend = {24'h000000, sh[7:0]};
            3'b101:  load_extend = {16'h0000, sh[15:0]};
            default: load_extend = sh;
        endcase
    endfunction

    // Byte offset actually used: halfwords ignore addr[0], words always use lane 0.
    always_comb begin
        offset_s = 2'b00;
        case (funct3[1:0])
            2'b00:   offset_s = addr[1:0];
            2'b01:   offset_s = {addr[1], 1'b0};
            default: offset_s = 2'b00;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned_s;
    assign misaligned_s = (funct3[1:0] == 2'b01) ? addr[0] :
                          (funct3[1:0] == 2'b00) ? 1'b0 : (addr[1:0] != 2'b00);
    assign legal_s  = ~misaligned_s;
    assign misalign = ~reset & (state_r == IDLE) & req_valid & misaligned_s;
`else
    assign legal_s  = 1'b1;
    assign misalign = 1'b0;
`endif

    assign accept_s = (state_r == IDLE) & req_valid & legal_s;
    assign stall    = ~reset & (accept_s | (state_r == BUSY));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; a request seen in DONE belongs to the retiring instruction.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Bus fields latch on accept and hold until the next accept; load result captured on ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0000_0000;
            mem_wstrb <= 4'b0000;
            mem_wdata <= 32'h0000_0000;
            ld_data   <= 32'h0000_0000;
            ld_valid  <= 1'b0;
            offset_r  <= 2'b00;
            funct3_r  <= 3'b000;
        end else begin
            ld_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        mem_req   <= 1'b1;
                        mem_we    <= req_we;
                        mem_addr  <= {addr[31:2], 2'b00};
                        mem_wstrb <= req_we ? lane_strb(funct3, offset_s) : 4'b0000;
                        mem_wdata <= req_we ? lane_data(funct3, store_data) : 32'h0000_0000;
                        offset_r  <= offset_s;
                        funct3_r  <= funct3;
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            ld_data  <= load_extend(funct3_r, offset_r, mem_rdata);
                            ld_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit; honours LSU_MISALIGN_TRAP_EN when defined.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        stall;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        misalign;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int checks = 0;
    int failures = 0;

    int          cap_stall;
    int          cap_req;
    logic        cap_stable;
    logic        cap_done;
    logic        cap_misalign;
    logic [31:0] cap_addr;
    logic [3:0]  cap_strb;
    logic [31:0] cap_wdata;
    logic        cap_we;
    logic        cap_ld_valid;
    logic [31:0] cap_ld_data;

    always #5 clk = ~clk;

    load_store_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .stall      (stall),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .misalign   (misalign),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One access; mem_ready is held low for 'waits' BUSY cycles before completing.
    task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] sd, input logic [31:0] rd, input int waits);
        int busy;
        req_valid = 1'b1; req_we = we; funct3 = f3; addr = a;
        store_data = sd; mem_rdata = rd; mem_ready = 1'b0;
        cap_stall = 0; cap_stable = 1'b1; cap_done = 1'b0; busy = 0;
        cap_ld_valid = 1'b0; cap_ld_data = 32'h0;
        #1;
        cap_misalign = misalign;
        for (int n = 0; n < 40; n++) begin
            if (n > 0 && !stall && !mem_req) begin
                cap_done = 1'b1;
                cap_ld_valid = ld_valid;
                cap_ld_data = ld_data;
                break;
            end
            if (stall) cap_stall++;
            if (mem_req) begin
                if (busy == 0) begin
                    cap_addr = mem_addr; cap_strb = mem_wstrb;
                    cap_wdata = mem_wdata; cap_we = mem_we;
                end else if (mem_addr !== cap_addr || mem_wstrb !== cap_strb ||
                             mem_wdata !== cap_wdata || mem_we !== cap_we) begin
                    cap_stable = 1'b0;
                end
                busy++;
                mem_ready = (busy > waits);
            end else begin
                mem_ready = 1'b0;
            end
            @(posedge clk); #1;
        end
        cap_req = busy;
        check_value("access_done", 32'(cap_done), 32'h1);
        req_valid = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] rd, input logic [31:0] exp);
        run_access(1'b0, f3, a, 32'h0, rd, 0);
        check_value({tag, "_ld_valid"}, 32'(cap_ld_valid), 32'h1);
        check_value({tag, "_ld_data"}, cap_ld_data, exp);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; funct3 = 3'b000;
        addr = 32'h0; store_data = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
        @(posedge clk); @(posedge clk); #1;
        check_value("rst_mem_req", 32'(mem_req), 32'h0);
        check_value("rst_mem_we", 32'(mem_we), 32'h0);
        check_value("rst_mem_addr", mem_addr, 32'h0);
        check_value("rst_wstrb", 32'(mem_wstrb), 32'h0);
        check_value("rst_wdata", mem_wdata, 32'h0);
        check_value("rst_ld_data", ld_data, 32'h0);
        check_value("rst_ld_valid", 32'(ld_valid), 32'h0);
        check_value("rst_stall", 32'(stall), 32'h0);
        check_value("rst_misalign", 32'(misalign), 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // LW 0x100, ready in first BUSY cycle
        run_access(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);
        check_value("lw_req_cycles", cap_req, 32'd1);
        check_value("lw_stall_cycles", cap_stall, 32'd2);
        check_value("lw_addr", cap_addr, 32'h0000_0100);
        check_value("lw_wstrb", 32'(cap_strb), 32'h0);
        check_value("lw_we", 32'(cap_we), 32'h0);
        check_value("lw_ld_valid", 32'(cap_ld_valid), 32'h1);
        check_value("lw_ld_data", cap_ld_data, 32'hDEAD_BEEF);

        // Load extraction, back-to-back
        check_load("lb_103", 3'b000, 32'h0000_0103, 32'h80FF_1234, 32'hFFFF_FF80);
        check_load("lbu_103", 3'b100, 32'h0000_0103, 32'h80FF_1234, 32'h0000_0080);
        check_load("lh_102", 3'b001, 32'h0000_0102, 32'h80FF_1234, 32'hFFFF_80FF);
        check_load("lhu_102", 3'b101, 32'h0000_0102, 32'h80FF_1234, 32'h0000_80FF);
        check_load("lb_100", 3'b000, 32'h0000_0100, 32'h80FF_1234, 32'h0000_0034);

        // Stores
        run_access(1'b1, 3'b000, 32'h0000_0201, 32'h0000_00A5, 32'h0, 0);
        check_value("sb_addr", cap_addr, 32'h0000_0200);
        check_value("sb_wstrb", 32'(cap_strb), 32'h2);
        check_value("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
        check_value("sb_we", 32'(cap_we), 32'h1);
        check_value("sb_ld_valid", 32'(cap_ld_valid), 32'h0);
        check_value("sb_ld_hold", cap_ld_data, 32'h0000_0034);
        check_value("sb_stall_cycles", cap_stall, 32'd2);

        run_access(1'b1, 3'b001, 32'h0000_0202, 32'h1234_BEEF, 32'h0, 0);
        check_value("sh_addr", cap_addr, 32'h0000_0200);
        check_value("sh_wstrb", 32'(cap_strb), 32'hC);
        check_value("sh_wdata", cap_wdata, 32'hBEEF_BEEF);

        // SW with ready low for the accept cycle and two BUSY cycles
        run_access(1'b1, 3'b010, 32'h0000_0300, 32'h1234_5678, 32'h0, 2);
        check_value("wait_stall_cycles", cap_stall, 32'd4);
        check_value("wait_req_cycles", cap_req, 32'd3);
        check_value("wait_stable", 32'(cap_stable), 32'h1);
        check_value("wait_wstrb", 32'(cap_strb), 32'hF);
        check_value("wait_wdata", cap_wdata, 32'h1234_5678);

        // Reset while BUSY
        req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h0000_0400; mem_ready = 1'b0;
        @(posedge clk); #1;
        check_value("mid_req_before", 32'(mem_req), 32'h1);
        reset = 1'b1;
        #1;
        check_value("mid_req_after", 32'(mem_req), 32'h0);
        check_value("mid_stall_after", 32'(stall), 32'h0);
        check_value("mid_ld_valid_after", 32'(ld_valid), 32'h0);
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_access(1'b1, 3'b010, 32'h0000_0500, 32'hCAFE_F00D, 32'h0, 0);
        check_value("post_rst_addr", cap_addr, 32'h0000_0500);
        check_value("post_rst_wstrb", 32'(cap_strb), 32'hF);
        check_value("post_rst_wdata", cap_wdata, 32'hCAFE_F00D);
        check_value("post_rst_stall", cap_stall, 32'd2);

`ifdef LSU_MISALIGN_TRAP_EN
        req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h0000_0102; mem_ready = 1'b1;
        #1;
        check_value("trap_misalign", 32'(misalign), 32'h1);
        check_value("trap_stall", 32'(stall), 32'h0);
        check_value("trap_req", 32'(mem_req), 32'h0);
        @(posedge clk); #1;
        check_value("trap_req_next", 32'(mem_req), 32'h0);
        check_value("trap_ld_valid", 32'(ld_valid), 32'h0);
        req_valid = 1'b0;
        #1;
        check_value("trap_misalign_clear", 32'(misalign), 32'h0);
        @(posedge clk); #1;
        check_load("trap_then_lw", 3'b010, 32'h0000_0104, 32'h5566_7788, 32'h5566_7788);
`else
        run_access(1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'h1122_3344, 0);
        check_value("mis_lw_misalign", 32'(cap_misalign), 32'h0);
        check_value("mis_lw_addr", cap_addr, 32'h0000_0100);
        check_value("mis_lw_data", cap_ld_data, 32'h1122_3344);
        check_load("mis_lh_103", 3'b001, 32'h0000_0103, 32'h80FF_1234, 32'hFFFF_80FF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit downstream of the execute ALU: it consumes the ALU result as the effective address for loads and stores. It aligns store data into byte lanes and runs a valid/ready handshake on the data-memory bus. It returns sign/zero-extended load data for register writeback. The core stalls while an access is in flight, which lets the single-cycle datapath use a multi-cycle memory.

## Interface
- `WIDTH`, 32, data/address width (only 32 supported)
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high
- `req_valid`  in  1  current instruction is a load/store; held stable while `stall`=1
- `req_we`  in  1  1=store, 0=load
- `funct3`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes decode as W
- `addr`  in  32  effective address (ALU output)
- `store_data`  in  32  rs2 value
- `stall`  out  1  freeze PC/regfile write
- `ld_valid`  out  1  `ld_data` valid this cycle (load only)
- `ld_data`  out  32  extended load result
- `misalign`  out  1  misaligned access flag
- `mem_req`  out  1  bus request
- `mem_we`  out  1  bus write
- `mem_addr`  out  32  word-aligned address ({addr[31:2],2'b00})
- `mem_wstrb`  out  4  byte enables
- `mem_wdata`  out  32  lane-replicated store data
- `mem_ready`  in  1  bus accept/complete
- `mem_rdata`  in  32  read data, valid with `mem_ready` on loads

## Operation
- FSM states:
  - IDLE: `req_valid` with a legal access latches addr[1:0], funct3, req_we and the bus fields, then goes to BUSY.
  - BUSY: `mem_req`=1; on `mem_ready`, capture the load result and go to DONE.
  - DONE: go unconditionally to IDLE.
- `req_valid` seen during DONE belongs to the retiring instruction and is ignored.
- `stall` = (IDLE & `req_valid` & legal) | BUSY. It is combinational and is 0 in DONE and during reset.
- Store lanes:
  - SB: `wstrb` = 1<<addr[1:0]; `wdata` = byte replicated ×4.
  - SH: `wstrb` = addr[1] ? 1100 : 0011; `wdata` = half replicated ×2.
  - SW: `wstrb` = 1111.
- Loads drive `wstrb`=0000.
- Load extract: shift `mem_rdata` right by 8·addr[1:0], then sign-extend from bit 7 (B) or bit 15 (H), or zero-extend (BU, HU). W passes through.
- `ld_data` is registered and holds its last value until the next load completes. `ld_valid`=1 only in DONE after a load.
- Bus fields stay stable while `mem_req`=1. `mem_ready` is ignored when `mem_req`=0.

## Timing
- Reset values: all registered outputs are 0 (`mem_req`, `mem_we`, `mem_addr`, `mem_wstrb`, `mem_wdata`, `ld_data`, `ld_valid`). `misalign`=0, `stall`=0, state IDLE.
- Minimum access: 3 cycles (IDLE accept, BUSY with `mem_ready`=1, DONE). Each cycle of `mem_ready`=0 adds one BUSY cycle; no timeout.
- Back-to-back accesses: the next instruction's IDLE accept comes in the cycle after DONE.
- Reset mid-access: asynchronous return to IDLE; `mem_req` drops immediately and the in-flight transaction is abandoned.

## Configuration
- With `LSU_MISALIGN_TRAP_EN` defined, a misaligned access raises `misalign`=1 combinationally for one cycle. Misaligned means H/HU with addr[0]=1, or W with addr[1:0]≠0.
  - There is no bus access.
  - `stall`=0, `ld_valid`=0, and the FSM stays in IDLE.
- Without it, `misalign` is tied to 0 and the offending low address bits are forced to 0. H uses addr[1] only; W uses word lane 0. The access then proceeds normally.

## Test plan
- LW at 0x100, `mem_rdata`=0xDEADBEEF, `mem_ready` high in the first BUSY cycle:
  - `mem_req` is high 1 cycle with `mem_addr`=0x100 and `wstrb`=0000.
  - `stall` is high for 2 cycles.
  - In DONE, `ld_valid`=1 and `ld_data`=0xDEADBEEF.
- LB at 0x103 with `rdata`=0x80FF_1234 returns `ld_data`=0xFFFFFF80. LBU at the same address returns 0x00000080. LH at 0x102 returns 0xFFFF80FF.
- SB at 0x201 with `store_data`=0x000000A5 drives `mem_addr`=0x200, `wstrb`=0010, `wdata`=0xA5A5A5A5, `we`=1. SH at 0x202 drives `wstrb`=1100.
- Bus wait of 3 cycles (`mem_ready` low): `stall` stays high for 4 cycles, and `mem_addr`, `wstrb` and `wdata` stay stable throughout.
- Reset asserted during BUSY: `mem_req`, `stall` and `ld_valid` go to 0 immediately. After release, a new SW completes normally.
- LW at 0x102:
  - With the macro: `misalign`=1 for 1 cycle, `mem_req` never asserts, `stall`=0.
  - Without the macro: access to 0x100, `misalign`=0.
